// File: rtl/pz_frame_loader.sv
// rtl/pz_frame_loader.sv - header/term frame loader that feeds a 3-stage pole/zero accumulator and returns its result
module pz_frame_loader #(
  parameter int REG_FILE_SIZE = 8,
  parameter int DATA_SIZE     = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               s_hdr,
  input  logic [DATA_SIZE-1:0]               s_data,
  output logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
  output logic [31:0]                        no_z,
  output logic [31:0]                        no_p,
  output logic                               acc_ready,
  input  logic [DATA_SIZE-1:0]               acc_pz,
  output logic                               res_valid,
  output logic [DATA_SIZE-1:0]               res_data,
  input  logic                               res_ready,
  output logic                               err
);

  localparam int CW = $clog2(REG_FILE_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESULT} state_t;

  state_t                             r_state;
  logic                               r_s_ready;
  logic                               r_acc_ready;
  logic                               r_res_valid;
  logic                               r_err;
  logic [DATA_SIZE-1:0]               r_res_data;
  logic [DATA_SIZE*REG_FILE_SIZE-1:0] r_flat_pz;
  logic [3:0]                         r_nz;
  logic [3:0]                         r_np;
  logic [4:0]                         r_total;
  logic [CW-1:0]                      r_cnt;
  logic [1:0]                         r_run_cnt;

  logic          w_beat;
  logic [4:0]    w_hdr_sum;
  logic          w_hdr_ok;
  logic [CW-1:0] w_cnt_next;

  assign w_beat     = s_valid && r_s_ready;
  assign w_hdr_sum  = {1'b0, s_data[3:0]} + {1'b0, s_data[7:4]};
  assign w_hdr_ok   = 32'(w_hdr_sum) <= 32'(REG_FILE_SIZE);
  assign w_cnt_next = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_s_ready   <= 1'b0;
      r_acc_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_res_data  <= '0;
      r_flat_pz   <= '0;
      r_nz        <= '0;
      r_np        <= '0;
      r_total     <= '0;
      r_cnt       <= '0;
      r_run_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE, LOAD: begin
          r_s_ready <= 1'b1;
          if (w_beat && s_hdr) begin
            // A header inside LOAD aborts the frame; an oversize header always errors
            if (r_state == LOAD || !w_hdr_ok) r_err <= 1'b1;
            if (w_hdr_ok) begin
              r_nz      <= s_data[3:0];
              r_np      <= s_data[7:4];
              r_total   <= w_hdr_sum;
              r_flat_pz <= '0;
              r_cnt     <= '0;
              if (w_hdr_sum == 5'd0) begin
                r_state     <= RUN;
                r_s_ready   <= 1'b0;
                r_acc_ready <= 1'b1;
                r_run_cnt   <= '0;
              end else begin
                r_state <= LOAD;
              end
            end else begin
              r_state <= IDLE;
            end
          end else if (w_beat && r_state == LOAD) begin
            r_flat_pz[DATA_SIZE*r_cnt +: DATA_SIZE] <= s_data;
            r_cnt <= w_cnt_next;
            if (32'(w_cnt_next) == 32'(r_total)) begin
              r_state     <= RUN;
              r_s_ready   <= 1'b0;
              r_acc_ready <= 1'b1;
              r_run_cnt   <= '0;
            end
          end
        end
        RUN: begin
          // Three advance strobes fill the accumulator pipe; the fourth cycle samples its output
          r_run_cnt <= r_run_cnt + 2'd1;
          if (r_run_cnt == 2'd2) r_acc_ready <= 1'b0;
          if (r_run_cnt == 2'd3) begin
            r_res_data  <= acc_pz;
            r_res_valid <= 1'b1;
            r_state     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_s_ready   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign acc_ready = r_acc_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign err       = r_err;
  assign flat_pz   = r_flat_pz;
  assign no_z      = {28'd0, r_nz};
  assign no_p      = {28'd0, r_np};

endmodule

// File: tb/tb_pz_frame_loader.sv
// tb/tb_pz_frame_loader.sv - randomized self-checking bench for pz_frame_loader
module tb_pz_frame_loader;

  localparam int RFS = 8;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_hdr = 1'b0;
  logic [DW-1:0]     s_data = '0;
  logic              res_ready = 1'b0;
  logic              s_ready;
  logic              acc_ready;
  logic              res_valid;
  logic              err;
  logic [DW-1:0]     acc_pz;
  logic [DW-1:0]     res_data;
  logic [DW*RFS-1:0] flat_pz;
  logic [31:0]       no_z;
  logic [31:0]       no_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pz_frame_loader #(.REG_FILE_SIZE(RFS), .DATA_SIZE(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_hdr     (s_hdr),
    .s_data    (s_data),
    .flat_pz   (flat_pz),
    .no_z      (no_z),
    .no_p      (no_p),
    .acc_ready (acc_ready),
    .acc_pz    (acc_pz),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .err       (err)
  );

  // Stand-in for the downstream accumulator: a 3-deep pipe advanced only by acc_ready
  logic [DW-1:0] acc_pipe [3];

  function automatic logic [DW-1:0] pz_sum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < RFS; i++) begin
      if (i < no_z) s += flat_pz[DW*i +: DW];
      else if (i < no_z + no_p) s -= flat_pz[DW*i +: DW];
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (!resetn || (res_valid && res_ready)) begin
      for (int i = 0; i < 3; i++) acc_pipe[i] <= 8'hA5;
    end else if (acc_ready) begin
      acc_pipe[0] <= pz_sum();
      acc_pipe[1] <= acc_pipe[0];
      acc_pipe[2] <= acc_pipe[1];
    end
  end
  assign acc_pz = acc_pipe[2];

  // Reference model of the frame contents
  logic [DW-1:0] m_slots [RFS];
  int            m_nz = 0;
  int            m_np = 0;
  int            m_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*RFS-1:0] exp_flat();
    logic [DW*RFS-1:0] f = '0;
    for (int i = 0; i < RFS; i++) f[DW*i +: DW] = m_slots[i];
    return f;
  endfunction

  function automatic logic [DW-1:0] exp_res();
    int s = 0;
    for (int i = 0; i < m_nz; i++) s += int'(m_slots[i]);
    for (int i = m_nz; i < m_nz + m_np; i++) s -= int'(m_slots[i]);
    return DW'(s);
  endfunction

  task automatic m_clear(input int nz, input int np);
    m_nz = nz;
    m_np = np;
    m_cnt = 0;
    for (int i = 0; i < RFS; i++) m_slots[i] = '0;
  endtask

  task automatic beat(input logic hdr, input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_hdr   = hdr;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    s_hdr   = 1'b0;
    s_data  = DW'($urandom);
  endtask

  task automatic send_hdr(input logic [3:0] nz, input logic [3:0] np);
    m_clear(int'(nz), int'(np));
    beat(1'b1, {np, nz});
  endtask

  task automatic send_term(input logic [DW-1:0] d);
    m_slots[m_cnt] = d;
    m_cnt++;
    beat(1'b0, d);
  endtask

  task automatic finish_frame(input string tag, input int hold);
    int cyc = 0;
    int accs = 0;
    bit sready_low = 1'b1;
    bit stable = 1'b1;
    while (!res_valid && cyc < 20) begin
      if (acc_ready) accs++;
      if (s_ready) sready_low = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, " res_valid"}, res_valid, 1);
    check_eq({tag, " latency"}, cyc, 4);
    check_eq({tag, " acc_cycles"}, accs, 3);
    check_eq({tag, " s_ready_run"}, sready_low, 1);
    check_eq({tag, " flat_pz"}, flat_pz, exp_flat());
    check_eq({tag, " no_z"}, no_z, m_nz);
    check_eq({tag, " no_p"}, no_p, m_np);
    check_eq({tag, " res_data"}, res_data, exp_res());
    for (int i = 0; i < hold; i++) begin
      if (!res_valid || res_data !== exp_res() || s_ready || acc_ready) stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) check_eq({tag, " hold_stable"}, stable, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq({tag, " res_valid_drop"}, res_valid, 0);
    check_eq({tag, " s_ready_idle"}, s_ready, 1);
    check_eq({tag, " flat_retained"}, flat_pz, exp_flat());
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " s_ready"}, s_ready, 0);
    check_eq({tag, " flat_pz"}, flat_pz, 0);
    check_eq({tag, " no_z"}, no_z, 0);
    check_eq({tag, " no_p"}, no_p, 0);
    check_eq({tag, " acc_ready"}, acc_ready, 0);
    check_eq({tag, " res_valid"}, res_valid, 0);
    check_eq({tag, " res_data"}, res_data, 0);
    check_eq({tag, " err"}, err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] nz;
    logic [3:0] np;
    bit quiet;

    m_clear(0, 0);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_eq("reset s_ready_after", s_ready, 1);

    // Non-header beat in IDLE is swallowed
    beat(1'b0, 8'h3C);
    check_eq("idle_discard s_ready", s_ready, 1);
    check_eq("idle_discard err", err, 0);
    check_eq("idle_discard flat", flat_pz, 0);

    // nz=2, np=1: 10+20-5
    send_hdr(4'd2, 4'd1);
    send_term(8'd10);
    send_term(8'd20);
    send_term(8'd5);
    finish_frame("basic", 0);
    check_eq("basic res_25", res_data, 8'd25);
    check_eq("basic slot2", flat_pz[23:16], 8'd5);
    check_eq("basic slots3_7", flat_pz[63:24], 0);

    // Empty frame skips LOAD
    send_hdr(4'd0, 4'd0);
    finish_frame("empty", 1);
    check_eq("empty res_0", res_data, 8'd0);

    // Single pole wraps to 0xFF
    send_hdr(4'd0, 4'd1);
    send_term(8'd1);
    finish_frame("wrap", 0);
    check_eq("wrap res_ff", res_data, 8'hFF);

    // Oversize header in IDLE
    beat(1'b1, {4'd4, 4'd5});
    check_eq("oversize err_pulse", err, 1);
    check_eq("oversize s_ready", s_ready, 1);
    @(negedge clk);
    check_eq("oversize err_single", err, 0);
    check_eq("oversize flat_kept", flat_pz, exp_flat());
    check_eq("oversize no_z_kept", no_z, m_nz);
    check_eq("oversize no_p_kept", no_p, m_np);
    send_hdr(4'd3, 4'd2);
    for (int k = 0; k < 5; k++) send_term(DW'($urandom));
    finish_frame("post_oversize", 0);

    // Consumer stalls for 5 cycles
    send_hdr(4'd4, 4'd4);
    for (int k = 0; k < 8; k++) send_term(DW'($urandom));
    finish_frame("stall", 5);

    // Header mid-LOAD aborts and restarts
    send_hdr(4'd3, 4'd3);
    send_term(8'd40);
    send_term(8'd41);
    send_hdr(4'd1, 4'd0);
    check_eq("abort err_pulse", err, 1);
    check_eq("abort s_ready", s_ready, 1);
    check_eq("abort flat_cleared", flat_pz, 0);
    @(negedge clk);
    check_eq("abort err_single", err, 0);
    send_term(8'd7);
    finish_frame("abort", 0);
    check_eq("abort res_7", res_data, 8'd7);

    // Oversize header mid-LOAD drops back to IDLE, where a term beat is ignored
    send_hdr(4'd2, 4'd2);
    send_term(8'h55);
    beat(1'b1, {4'd15, 4'd15});
    check_eq("load_oversize err", err, 1);
    beat(1'b0, 8'h66);
    check_eq("load_oversize err_single", err, 0);
    check_eq("load_oversize flat", flat_pz, exp_flat());
    check_eq("load_oversize acc_ready", acc_ready, 0);

    // Reset mid-LOAD
    send_hdr(4'd2, 4'd2);
    send_term(8'h11);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_load");
    resetn = 1'b1;
    m_clear(0, 0);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid || acc_ready || err) quiet = 1'b0;
    end
    check_eq("rst_load quiet", quiet, 1);
    check_eq("rst_load s_ready", s_ready, 1);

    // Reset mid-RUN
    send_hdr(4'd1, 4'd0);
    send_term(8'd9);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_clear(0, 0);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid || acc_ready) quiet = 1'b0;
    end
    check_eq("rst_run quiet", quiet, 1);
    check_eq("rst_run res_data", res_data, 0);
    check_eq("rst_run flat", flat_pz, 0);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      nz = 4'($urandom_range(0, RFS));
      np = 4'($urandom_range(0, RFS - int'(nz)));
      if ($urandom_range(0, 3) == 0) beat(1'b0, DW'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        beat(1'b1, {4'd8, 4'($urandom_range(1, 7))});
        check_eq("rnd oversize_err", err, 1);
      end
      send_hdr(nz, np);
      for (int k = 0; k < int'(nz) + int'(np); k++) send_term(DW'($urandom));
      finish_frame("rnd", $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
